uart_write: RTL

UART_WRITE -- requirements
Module: uart_write

---
 rtl/uart_write.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_write.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a 16x-oversampled
// serialiser. fsm_state mirrors the FSM register (0 IDLE, 1 START, 2 DATA, 3 STOP).
module uart_write #(
  parameter int baudrate   = 9600,
  parameter int freq       = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] Data_in,
  output logic       full,
  output logic       busy,
  output logic       Serial_out,
  output logic       TX_done,
  output logic [1:0] fsm_state
);

  localparam int DIV_RAW = freq / (baudrate * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Oversampling tick: free-running, one pulse every DIV clocks.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Write handshake: a byte is taken on any rising edge with wr_en=1 and
  // full=0; with full=1 the write is simply lost (there is no retry).
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          empty;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser
  state_t     state;
  state_t     state_nx;
  logic [3:0] bit_tick;
  logic [3:0] bit_tick_nx;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_nx;
  logic [7:0] shift;
  logic [7:0] shift_nx;
  logic       serial_nx;
  logic       done_nx;
  logic       bit_end;

  assign bit_end   = tick && (bit_tick == 4'd15);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_tick   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      Serial_out <= 1'b1;
      TX_done    <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_tick   <= bit_tick_nx;
      bit_idx    <= bit_idx_nx;
      shift      <= shift_nx;
      Serial_out <= serial_nx;
      TX_done    <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bit_tick_nx = bit_tick;
    bit_idx_nx  = bit_idx;
    shift_nx    = shift;
    serial_nx   = Serial_out;
    done_nx     = 1'b0;
    pop         = 1'b0;

    // The 4-bit counter wraps 15 -> 0 exactly when a bit period ends.
    if (state != IDLE && tick) begin
      bit_tick_nx = bit_tick + 4'd1;
    end

    case (state)
      IDLE: begin
        serial_nx = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          shift_nx    = mem[rd_ptr];
          bit_tick_nx = '0;
          serial_nx   = 1'b0;
          state_nx    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = '0;
          serial_nx  = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx  = STOP;
            serial_nx = 1'b1;
          end else begin
            shift_nx   = {1'b0, shift[7:1]};
            bit_idx_nx = bit_idx + 3'd1;
            serial_nx  = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
